// File: rtl/brnch_pkg.sv
// Shared definitions for the branch resolution queue: PC width, queue entry
// record and default queue depth.
package brnch_pkg;

    localparam int PC_W          = 16;
    localparam int BRQ_DEPTH_DEF = 8;

    typedef struct packed {
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] fall;
        logic            pred;
    } brq_entry_t;

    // Build a queue entry from its three fields.
    function automatic brq_entry_t mk_entry(input logic [PC_W-1:0] tgt,
                                            input logic [PC_W-1:0] fall,
                                            input logic            pred);
        brq_entry_t e;
        e.tgt  = tgt;
        e.fall = fall;
        e.pred = pred;
        return e;
    endfunction

endpackage

// File: rtl/brq_store.sv
// Entry storage for the branch resolution queue: DEPTH registers, two write
// ports (older slot on port 0) and one asynchronous read port at the head.
// Storage holds pure data and is not reset; occupancy is tracked by the owner.
module brq_store
    import brnch_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [PW-1:0] wa0,
    input  brq_entry_t    wd0,
    input  logic          we1,
    input  logic [PW-1:0] wa1,
    input  brq_entry_t    wd1,
    input  logic [PW-1:0] ra,
    output brq_entry_t    rd
);

    brq_entry_t mem [DEPTH];

    // Write both enqueue slots; addresses never collide when both are enabled.
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/brnch_rslv_q.sv
// Branch resolution queue. Holds in-flight predicted branches in program
// order, resolves the oldest one, and emits a registered mispredict pulse and
// corrected PC. A mispredict flushes the queue and drops same-cycle enqueues.
// Optional feature: define BRQ_STATS_EN to add saturating resolve/mispredict
// counters on ports stat_rslv and stat_mispred.
module brnch_rslv_q
    import brnch_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_vld0,
    input  logic                     enq_vld1,
    input  logic [PC_W-1:0]          enq_tgt0,
    input  logic [PC_W-1:0]          enq_tgt1,
    input  logic [PC_W-1:0]          enq_fall0,
    input  logic [PC_W-1:0]          enq_fall1,
    input  logic                     enq_pred0,
    input  logic                     enq_pred1,
    output logic                     enq_rdy,
    input  logic                     rslv_vld,
    input  logic                     rslv_tkn,
    output logic                     mispred,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     ovf_err
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]              stat_rslv,
    output logic [15:0]              stat_mispred
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    brq_entry_t    head_ent;

    logic          enq_any;
    logic          pop;
    logic          mis;
    logic          acc;
    logic [CW-1:0] nenq;
    logic          we0;
    logic          we1;
    logic [PW-1:0] wa1;

    assign enq_rdy = (q_cnt <= CW'(DEPTH - 2));

    brq_store #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_store (
        .clk (clk),
        .we0 (we0),
        .wa0 (tail),
        .wd0 (mk_entry(enq_tgt0, enq_fall0, enq_pred0)),
        .we1 (we1),
        .wa1 (wa1),
        .wd1 (mk_entry(enq_tgt1, enq_fall1, enq_pred1)),
        .ra  (head),
        .rd  (head_ent)
    );

    // Decode this cycle's resolve and enqueue; a mispredict squashes enqueues.
    always_comb begin
        enq_any = enq_vld0 | enq_vld1;
        pop     = rslv_vld & (q_cnt != '0);
        mis     = pop & (rslv_tkn != head_ent.pred);
        acc     = enq_any & enq_rdy & ~mis;
        nenq    = '0;
        if (acc) nenq = CW'(enq_vld0) + CW'(enq_vld1);
        we0     = acc & enq_vld0;
        we1     = acc & enq_vld1;
        wa1     = tail + PW'(enq_vld0);
    end

    // Pointer/occupancy update, registered resolve outputs and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            q_cnt       <= '0;
            mispred     <= 1'b0;
            redirect_pc <= '0;
            ovf_err     <= 1'b0;
        end else begin
            if (mis) begin
                head  <= tail;
                q_cnt <= '0;
            end else begin
                head  <= head + PW'(pop);
                tail  <= tail + PW'(nenq);
                q_cnt <= q_cnt + nenq - CW'(pop);
            end
            mispred <= mis;
            if (pop) redirect_pc <= rslv_tkn ? head_ent.tgt : head_ent.fall;
            if (enq_any && !enq_rdy) ovf_err <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Saturating counters of resolves and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rslv    <= '0;
            stat_mispred <= '0;
        end else begin
            stat_rslv    <= sat_inc(stat_rslv, pop);
            stat_mispred <= sat_inc(stat_mispred, mis);
        end
    end
`endif

endmodule

// File: tb/tb_brnch_rslv_q.sv
// Bench for brnch_rslv_q: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_brnch_rslv_q;

    localparam int DEPTH = 8;

    typedef struct {
        logic [15:0] tgt;
        logic [15:0] fall;
        logic        pred;
    } ment_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq_vld0 = 0, enq_vld1 = 0;
    logic [15:0] enq_tgt0 = 0, enq_tgt1 = 0, enq_fall0 = 0, enq_fall1 = 0;
    logic        enq_pred0 = 0, enq_pred1 = 0;
    logic        enq_rdy;
    logic        rslv_vld = 0, rslv_tkn = 0;
    logic        mispred;
    logic [15:0] redirect_pc;
    logic [3:0]  q_cnt;
    logic        ovf_err;
`ifdef BRQ_STATS_EN
    logic [15:0] stat_rslv, stat_mispred;
`endif

    brnch_rslv_q #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_vld0    (enq_vld0),
        .enq_vld1    (enq_vld1),
        .enq_tgt0    (enq_tgt0),
        .enq_tgt1    (enq_tgt1),
        .enq_fall0   (enq_fall0),
        .enq_fall1   (enq_fall1),
        .enq_pred0   (enq_pred0),
        .enq_pred1   (enq_pred1),
        .enq_rdy     (enq_rdy),
        .rslv_vld    (rslv_vld),
        .rslv_tkn    (rslv_tkn),
        .mispred     (mispred),
        .redirect_pc (redirect_pc),
        .q_cnt       (q_cnt),
        .ovf_err     (ovf_err)
`ifdef BRQ_STATS_EN
        ,
        .stat_rslv   (stat_rslv),
        .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    // reference model state
    ment_t       mq[$];
    logic        exp_mis = 0;
    logic [15:0] exp_pc = 0;
    logic        exp_ovf = 0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q_cnt"},   32'(q_cnt),       32'(mq.size()));
        check({tag, ".mispred"}, 32'(mispred),     32'(exp_mis));
        check({tag, ".pc"},      32'(redirect_pc), 32'(exp_pc));
        check({tag, ".ovf"},     32'(ovf_err),     32'(exp_ovf));
    endtask

    // One clock cycle: drive inputs, check enq_rdy, advance model, check outputs.
    task automatic step(input string tag,
                        input logic v0, input logic [15:0] t0, input logic [15:0] f0, input logic p0,
                        input logic v1, input logic [15:0] t1, input logic [15:0] f1, input logic p1,
                        input logic rv, input logic rt);
        logic  rdy;
        logic  mis;
        ment_t h;
        @(negedge clk);
        enq_vld0 = v0; enq_tgt0 = t0; enq_fall0 = f0; enq_pred0 = p0;
        enq_vld1 = v1; enq_tgt1 = t1; enq_fall1 = f1; enq_pred1 = p1;
        rslv_vld = rv; rslv_tkn = rt;
        #1;
        rdy = (mq.size() <= DEPTH - 2);
        check({tag, ".enq_rdy"}, 32'(enq_rdy), 32'(rdy));
        mis = 1'b0;
        if (rv && mq.size() > 0) begin
            h      = mq.pop_front();
            mis    = (rt != h.pred);
            exp_pc = rt ? h.tgt : h.fall;
        end
        if ((v0 || v1) && !rdy) exp_ovf = 1'b1;
        else if (!mis) begin
            if (v0) mq.push_back('{t0, f0, p0});
            if (v1) mq.push_back('{t1, f1, p1});
        end
        if (mis) mq.delete();
        exp_mis = mis;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic enq1(input string tag, input logic [15:0] t, input logic [15:0] f, input logic p);
        step(tag, 1, t, f, p, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq2(input string tag, input logic [15:0] t0, input logic [15:0] f0, input logic p0,
                        input logic [15:0] t1, input logic [15:0] f1, input logic p1);
        step(tag, 1, t0, f0, p0, 1, t1, f1, p1, 0, 0);
    endtask

    task automatic rslv(input string tag, input logic tkn);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, tkn);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle, check the forced values while held, then release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        enq_vld0 = 0; enq_vld1 = 0; rslv_vld = 0; rslv_tkn = 0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        exp_mis = 0; exp_pc = 0; exp_ovf = 0;
        check({tag, ".enq_rdy"}, 32'(enq_rdy), 32'd1);
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic v0, v1, p0, p1, rv, rt;
        logic [15:0] t0, f0, t1, f1;

        // reset from time zero
        #1;
        check("rst0.enq_rdy", 32'(enq_rdy), 32'd1);
        check_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // dual enqueue, both predicted taken and resolved taken
        enq2("dual", 16'h0040, 16'h0041, 1'b1, 16'h0050, 16'h0051, 1'b1);
        rslv("dual_r0", 1'b1);
        rslv("dual_r1", 1'b1);

        // predicted taken, actually not taken -> redirect to fall-through
        enq1("mp", 16'h0020, 16'h0013, 1'b1);
        rslv("mp_r", 1'b0);
        idle("mp_pulse");

        // fill to DEPTH-1 then overflow attempt; ovf_err is sticky
        enq2("fill0", 16'h0100, 16'h0101, 1'b1, 16'h0110, 16'h0111, 1'b0);
        enq2("fill1", 16'h0120, 16'h0121, 1'b0, 16'h0130, 16'h0131, 1'b1);
        enq2("fill2", 16'h0140, 16'h0141, 1'b1, 16'h0150, 16'h0151, 1'b0);
        enq1("fill3", 16'h0160, 16'h0161, 1'b1);
        enq1("ovf", 16'h0170, 16'h0171, 1'b1);
        idle("ovf_hold");
        for (int i = 0; i < 7; i++) rslv("drain", mq[0].pred);
        rslv("empty_rslv", 1'b0);

        // 20 single enqueue/resolve pairs to wrap the pointers
        for (int i = 0; i < 20; i++) begin
            enq1("wrap_e", 16'(16'h1000 + i * 16'h11), 16'(16'h2000 + i * 16'h7), 1'(i % 2));
            rslv("wrap_r", 1'(i % 2));
        end

        // mispredict coincident with dual enqueue: enqueues are dropped
        enq1("sq_e", 16'h0300, 16'h0301, 1'b0);
        step("sq", 1, 16'h0400, 16'h0401, 1'b1, 1, 16'h0500, 16'h0501, 1'b1, 1, 1'b1);
        rslv("sq_empty", 1'b1);

        // reset with five entries in flight
        do_reset("rst_ovf");
        enq2("r5a", 16'h0600, 16'h0601, 1'b1, 16'h0610, 16'h0611, 1'b1);
        enq2("r5b", 16'h0620, 16'h0621, 1'b1, 16'h0630, 16'h0631, 1'b1);
        enq1("r5c", 16'h0640, 16'h0641, 1'b1);
        do_reset("rst_mid");
        rslv("rst_after", 1'b0);
        idle("rst_idle");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 3) != 0);
            v1 = 1'($urandom_range(0, 1));
            t0 = 16'($urandom); f0 = 16'($urandom); p0 = 1'($urandom);
            t1 = 16'($urandom); f1 = 16'($urandom); p1 = 1'($urandom);
            rv = 1'($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) rt = mq[0].pred;
            else rt = 1'($urandom);
            step("rand", v0, t0, f0, p0, v1, t1, f1, p1, rv, rt);
            if (i == 200) do_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
